bist_sig_analyzer: RTL and testbench

- Output-response analyser for the LFSR-driven BIST loop. It sits directly downstream of the circuit under test (CUT), e.g. the AND-gate system fed by the 4-bit LFSR.
- Gates the upstream pattern generator's enable for a fixed pattern count.
- Compacts the 1-bit CUT response into a single-input signature register (SISR), then compares the signature against a golden value and reports pass/fail.

---
 rtl/bist_pkg.sv | 12 +
 rtl/bist_sig_analyzer_if.sv | 13 +
 rtl/sisr_reg.sv | 18 +
 rtl/bist_sig_analyzer.sv | 64 ++++++
 tb/tb_bist_sig_analyzer.sv | 106 ++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, default parameters and counter sizing for the BIST analyser.
package bist_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CMP = 2'd2, DONE = 2'd3} state_t;
   localparam int         SIG_W_DEF  = 4;
   localparam logic [3:0] POLY_DEF   = 4'h3;
   localparam logic [3:0] SEED_DEF   = 4'h0;
   localparam int         N_PAT_DEF  = 15;
   localparam logic [3:0] GOLDEN_DEF = 4'h0;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/bist_sig_analyzer_if.sv
// bist_sig_analyzer_if: control, response and result signals between the BIST analyser and its user.
interface bist_sig_analyzer_if #(parameter int SIG_W = 4);
   logic             start;
   logic             resp_in;
   logic             lfsr_en;
   logic             busy;
   logic             done;
   logic             pass;
   logic             fail;
   logic [SIG_W-1:0] signature;
   modport master (output start, resp_in, input lfsr_en, busy, done, pass, fail, signature);
   modport slave  (input start, resp_in, output lfsr_en, busy, done, pass, fail, signature);
endinterface

// File: rtl/sisr_reg.sv
// sisr_reg: single-input signature register; load takes priority over shift.
module sisr_reg #(
   parameter int               SIG_W = 4,
   parameter logic [SIG_W-1:0] POLY  = 4'h3,
   parameter logic [SIG_W-1:0] SEED  = 4'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) sig <= SEED;
      else if (load) sig <= SEED;
      else if (shift_en) sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, din};
endmodule

// File: rtl/bist_sig_analyzer.sv
// bist_sig_analyzer: gates the pattern generator for N_PAT cycles, compacts the CUT response
// into a SISR and compares the final signature against GOLDEN.
module bist_sig_analyzer
   import bist_pkg::*;
#(
   parameter int               SIG_W  = SIG_W_DEF,
   parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
   parameter logic [SIG_W-1:0] SEED   = SEED_DEF,
   parameter int               N_PAT  = N_PAT_DEF,
   parameter logic [SIG_W-1:0] GOLDEN = GOLDEN_DEF
) (
   input logic                 clk,
   input logic                 rst,
   bist_sig_analyzer_if.slave  bus
);
   localparam int CW = cnt_w(N_PAT);
   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          load, last, match;
   always_comb begin
      load      = bus.start && (state == IDLE || state == DONE);
      last      = cnt == CW'(N_PAT - 1);
      match     = bus.signature == GOLDEN;
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = bus.start ? RUN : state;
         RUN:        state_nxt = last ? CMP : RUN;
         CMP:        state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bus.done <= 1'b0;
         bus.pass <= 1'b0;
         bus.fail <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            cnt      <= '0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail <= 1'b0;
         end else if (state == RUN) cnt <= cnt + 1'b1;
         else if (state == CMP) begin
            bus.done <= 1'b1;
            bus.pass <= match;
            bus.fail <= !match;
         end
      end
   // Decoded from the state register only, so start never reaches these combinationally.
   assign bus.lfsr_en = state == RUN;
   assign bus.busy    = state == RUN || state == CMP;
   sisr_reg #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_sisr (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (state == RUN),
      .din      (bus.resp_in),
      .sig      (bus.signature)
   );
endmodule

// File: tb/tb_bist_sig_analyzer.sv
// tb_bist_sig_analyzer: directed and randomized response streams checked against a GF(2) polynomial model.
module tb_bist_sig_analyzer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         total = 0;
   int         passed = 0;
   logic [3:0] fin;
   bist_sig_analyzer_if #(.SIG_W(4)) bus();
   bist_sig_analyzer dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // Signature as polynomial arithmetic: multiply by x, reduce modulo x^4+x+1, add the response bit.
   function automatic logic [3:0] nxt(input logic [3:0] s, input logic b);
      int v;
      v = int'(s) * 2;
      if (v >= 16) v = v ^ 'h13;
      return 4'(v ^ int'(b));
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   task automatic outs(input string tag, input logic en, input logic bsy, input logic dn,
                       input logic ps, input logic fl, input logic [3:0] sg);
      chk({tag, ".lfsr_en"}, 32'(bus.lfsr_en), 32'(en));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
      chk({tag, ".done"}, 32'(bus.done), 32'(dn));
      chk({tag, ".pass"}, 32'(bus.pass), 32'(ps));
      chk({tag, ".fail"}, 32'(bus.fail), 32'(fl));
      chk({tag, ".signature"}, 32'(bus.signature), 32'(sg));
   endtask
   task automatic run_test(input logic [14:0] pat, input bit poke, output logic [3:0] f);
      logic [3:0] s;
      s = 4'h0;
      bus.start   = 1'b1;
      bus.resp_in = 1'($urandom);
      tick();
      for (int i = 0; i < 15; i++) begin
         bus.resp_in = pat[i];
         bus.start   = poke && i == 6;
         outs("run", 1, 1, 0, 0, 0, s);
         tick();
         s = nxt(s, pat[i]);
      end
      bus.start   = poke;
      bus.resp_in = 1'($urandom);
      outs("cmp", 0, 1, 0, 0, 0, s);
      tick();
      bus.start = 1'b0;
      outs("done", 0, 0, 1, s == 4'h0, s != 4'h0, s);
      bus.resp_in = ~bus.resp_in;
      tick();
      outs("hold", 0, 0, 1, s == 4'h0, s != 4'h0, s);
      f = s;
   endtask
   initial begin
      bus.start   = 1'b1;
      bus.resp_in = 1'b0;
      repeat (4) begin
         bus.resp_in = ~bus.resp_in;
         tick();
         outs("reset", 0, 0, 0, 0, 0, 4'h0);
      end
      bus.start = 1'b0;
      rst       = 1'b1;
      repeat (3) begin
         bus.resp_in = 1'($urandom);
         tick();
         outs("idle", 0, 0, 0, 0, 0, 4'h0);
      end
      run_test(15'h0000, 1'b0, fin);
      chk("all_zero_sig", 32'(fin), 32'h0);
      run_test(15'h0001, 1'b0, fin);
      chk("single_one_sig", 32'(fin), 32'h9);
      run_test(15'h7fff, 1'b0, fin);
      chk("all_one_sig", 32'(fin), 32'h0);
      run_test(15'($urandom), 1'b1, fin);
      repeat (4) run_test(15'($urandom), 1'($urandom_range(0, 1)), fin);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (7) begin
         bus.resp_in = 1'($urandom);
         tick();
      end
      #3 rst = 1'b0;
      #1 outs("abort_run", 0, 0, 0, 0, 0, 4'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      outs("after_abort", 0, 0, 0, 0, 0, 4'h0);
      run_test(15'($urandom), 1'b0, fin);
      #3 rst = 1'b0;
      #1 outs("abort_done", 0, 0, 0, 0, 0, 4'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      run_test(15'h0001, 1'b1, fin);
      chk("final_single_one", 32'(fin), 32'h9);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
